// File: rtl/scrdescr_par.sv
// Parallel LFSR scrambler/descrambler, DATA_W bits per beat, one output register.
// Optional bypass port when SCRDESCR_BYPASS_EN is defined.
module scrdescr_par #(
   parameter int                DATA_W = 8,
   parameter int                LFSR_W = 7,
   parameter logic [LFSR_W-1:0] POLY   = 7'h60,
   parameter logic [LFSR_W-1:0] SEED   = 7'h7F,
   parameter int                MODE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              dir,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef SCRDESCR_BYPASS_EN
   ,
   input  logic              bypass
`endif
);

   logic [LFSR_W-1:0] state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   logic              accept;
   logic              byp;
   logic [LFSR_W-1:0] lfsr;
   logic [DATA_W-1:0] res;
   logic              b, fb, y, s;

   assign in_ready  = !out_valid_q || out_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   always_comb begin
      accept = in_valid && in_ready;
`ifdef SCRDESCR_BYPASS_EN
      byp = bypass;
`else
      byp = 1'b0;
`endif
      // start reloads before the beat is processed
      lfsr = start ? SEED : state_q;
      res  = '0;
      b    = 1'b0;
      fb   = 1'b0;
      y    = 1'b0;
      s    = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         b  = in_data[i];
         fb = ^(lfsr & POLY);
         y  = b ^ fb;
         if (MODE == 0) s = fb;
         else           s = dir ? b : y;
         res[i] = y;
         lfsr   = {lfsr[LFSR_W-2:0], s};
      end

      state_d = start ? SEED : state_q;
      if (accept && !byp) state_d = lfsr;

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = byp ? in_data : res;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SEED;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: tb/tb_scrdescr_par.sv
// Bench for scrdescr_par: MODE=0 instance against a bit-serial model,
// plus a MODE=1 scrambler->descrambler chain.
module tb_scrdescr_par;

   localparam int unsigned TB_POLY = 32'h60;
   localparam int unsigned TB_SEED = 32'h7F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start0 = 0, dir0 = 0, v0 = 0, ordy0 = 1;
   logic       irdy0, ov0;
   logic [7:0] d0 = 0, od0;
   logic       byp0 = 0;
   logic       zero = 1'b0;

   logic       s_start = 0, s_valid = 0, s_irdy, s_ov;
   logic [7:0] s_data = 0, s_od;
   logic       d_start = 0, d_irdy, d_ov;
   logic [7:0] d_od;
   logic       one = 1'b1, dir_s = 1'b0, dir_d = 1'b1;

   int errors = 0;
   int checks = 0;

   scrdescr_par #(.MODE(0)) u0 (
      .clk(clk), .rst(rst), .start(start0), .dir(dir0),
      .in_valid(v0), .in_ready(irdy0), .in_data(d0),
      .out_valid(ov0), .out_ready(ordy0), .out_data(od0)
`ifdef SCRDESCR_BYPASS_EN
      , .bypass(byp0)
`endif
   );

   scrdescr_par #(.MODE(1)) u_s (
      .clk(clk), .rst(rst), .start(s_start), .dir(dir_s),
      .in_valid(s_valid), .in_ready(s_irdy), .in_data(s_data),
      .out_valid(s_ov), .out_ready(d_irdy), .out_data(s_od)
`ifdef SCRDESCR_BYPASS_EN
      , .bypass(zero)
`endif
   );

   scrdescr_par #(.MODE(1)) u_d (
      .clk(clk), .rst(rst), .start(d_start), .dir(dir_d),
      .in_valid(s_ov), .in_ready(d_irdy), .in_data(s_od),
      .out_valid(d_ov), .out_ready(one), .out_data(d_od)
`ifdef SCRDESCR_BYPASS_EN
      , .bypass(zero)
`endif
   );

   // reference state: h bit k holds the bit fed back k+1 steps ago
   int unsigned h0, hs;
   bit          ov0m;
   logic [7:0]  q0[$];
   logic [7:0]  sq[$], dq[$], pt[$], ct[$];

   always @(negedge clk) begin
      if (s_ov && d_irdy) sq.push_back(s_od);
      if (d_ov) dq.push_back(d_od);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_beat(input int mode, input bit dr,
                             input int unsigned hin, input logic [7:0] d,
                             output int unsigned hout, output logic [7:0] q);
      int unsigned h;
      int unsigned b, fb, y, s;
      h = hin;
      q = 8'h00;
      for (int k = 7; k >= 0; k--) begin
         b  = d[k] ? 1 : 0;
         fb = 0;
         for (int t = 0; t < 7; t++)
            if (((TB_POLY >> t) & 1) == 1) fb = fb ^ ((h >> t) & 1);
         y  = b ^ fb;
         s  = (mode == 0) ? fb : (dr ? b : y);
         q[k] = (y == 1);
         h  = ((h << 1) | s) & 32'h7F;
      end
      hout = h;
   endtask

   task automatic drive0(input bit v, input logic [7:0] d, input bit rdy,
                         input bit st, input bit dr, input bit by);
      bit          acc, eb;
      logic [7:0]  y;
      int unsigned hn;
`ifdef SCRDESCR_BYPASS_EN
      eb = by;
`else
      eb = 1'b0;
`endif
      @(negedge clk);
      v0 = v; d0 = d; ordy0 = rdy; start0 = st; dir0 = dr; byp0 = eb;
      #1;
      chk("out_valid", ov0, ov0m);
      if (ov0m) chk("out_data", od0, q0[0]);
      chk("in_ready", irdy0, !ov0m || rdy);
      acc = v && (!ov0m || rdy);
      if (ov0m && rdy) void'(q0.pop_front());
      if (st) h0 = TB_SEED;
      if (acc) begin
         if (eb) y = d;
         else begin
            model_beat(0, dr, h0, d, hn, y);
            h0 = hn;
         end
         q0.push_back(y);
      end
      ov0m = acc ? 1'b1 : (rdy ? 1'b0 : ov0m);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; v0 = 0; s_valid = 0;
      #1;
      chk("rst_out_valid", ov0, 0);
      chk("rst_out_data", od0, 0);
      chk("rst_in_ready", irdy0, 1);
      chk("rst_pair_valid", {s_ov, d_ov}, 0);
      @(negedge clk);
      rst = 1'b0;
      h0 = TB_SEED; hs = TB_SEED; ov0m = 0; q0.delete();
   endtask

   task automatic run_pair(input bit restart_s, input bit chk_first);
      int unsigned hn;
      logic [7:0]  y;
      @(posedge clk);
      sq.delete(); dq.delete(); ct.delete();
      foreach (pt[i]) begin
         @(negedge clk);
         s_valid = 1; s_data = pt[i]; s_start = restart_s && (i == 0);
         #1;
         chk("pair_in_ready", s_irdy, 1);
         if (s_start) hs = TB_SEED;
         model_beat(1, 0, hs, pt[i], hn, y);
         hs = hn;
         ct.push_back(y);
      end
      @(negedge clk);
      s_valid = 0; s_start = 0;
      repeat (4) @(negedge clk);
      #1;
      chk("pair_cnt_s", sq.size(), pt.size());
      chk("pair_cnt_d", dq.size(), pt.size());
      foreach (ct[i]) begin
         if (i < sq.size()) chk("pair_cipher", sq[i], ct[i]);
         if (i < dq.size() && (chk_first || i > 0))
            chk("pair_plain", dq[i], pt[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      do_reset();

      // two zero beats from SEED
      drive0(1, 8'h00, 1, 0, 0, 0);
      drive0(1, 8'h00, 1, 0, 0, 0);
      chk("zero_beat0", od0, 8'h02);
      drive0(0, 8'h00, 1, 0, 0, 0);
      chk("zero_beat1", od0, 8'h0C);
      drive0(0, 8'h00, 1, 0, 0, 0);

      // 3-cycle stall with in_valid high
      drive0(1, 8'h11, 1, 0, 0, 0);
      drive0(1, 8'h22, 0, 0, 0, 0);
      chk("stall_in_ready", irdy0, 0);
      drive0(1, 8'h22, 0, 0, 0, 0);
      drive0(1, 8'h22, 0, 0, 0, 0);
      drive0(1, 8'h22, 1, 0, 0, 0);
      drive0(1, 8'h33, 1, 0, 0, 0);
      drive0(0, 8'h00, 1, 0, 0, 0);
      drive0(0, 8'h00, 1, 0, 0, 0);
      chk("stall_drained", q0.size(), 0);

      // start without accept, then with accept
      drive0(0, 8'h00, 1, 1, 0, 0);
      drive0(1, 8'h00, 1, 0, 0, 0);
      drive0(1, 8'h00, 1, 1, 0, 0);
      chk("start_noacc", od0, 8'h02);
      drive0(0, 8'h00, 1, 0, 0, 0);
      chk("start_acc", od0, 8'h02);

      // reset mid-stream with a held beat
      drive0(1, 8'h55, 0, 0, 0, 0);
      drive0(1, 8'h66, 0, 0, 0, 0);
      chk("pre_rst_valid", ov0, 1);
      do_reset();
      drive0(1, 8'h00, 1, 0, 0, 0);
      drive0(1, 8'h00, 1, 0, 0, 0);
      chk("rerun_beat0", od0, 8'h02);
      drive0(0, 8'h00, 1, 0, 0, 0);
      chk("rerun_beat1", od0, 8'h0C);

`ifdef SCRDESCR_BYPASS_EN
      do_reset();
      drive0(1, 8'hA5, 1, 0, 0, 1);
      drive0(1, 8'h00, 1, 0, 0, 0);
      chk("bypass_beat", od0, 8'hA5);
      drive0(0, 8'h00, 1, 0, 0, 0);
      chk("after_bypass", od0, 8'h02);
`endif

      // random traffic on the MODE=0 instance
      for (int n = 0; n < 400; n++)
         drive0(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                ($urandom % 29) == 0, 1'($urandom), ($urandom % 5) == 0);
      repeat (3) drive0(0, 8'h00, 1, 0, 0, 0);
      chk("rand_drained", q0.size(), 0);

      // MODE=1 chain
      do_reset();
      pt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_pair(0, 1);
      pt.delete();
      for (int n = 0; n < 20; n++) pt.push_back(8'($urandom));
      run_pair(0, 1);
      pt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_pair(1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
